// File: rtl/wb_common.sv
// Shared Wishbone B3 encodings and the burst master's state type.
package wb_common;

  // Cycle type identifier encodings
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INC     = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

  // Burst type extension: linear bursts only
  localparam logic [1:0] LINEAR  = 2'b00;

  // Burst master control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } bm_state_e;

  // CTI for the current beat: single-beat bursts stay classic, otherwise
  // incrementing until the final beat, which is flagged end-of-burst.
  function automatic logic [2:0] beat_cti(input logic single_s, input logic more_s);
    logic [2:0] cti_s;
    if (single_s) begin
      cti_s = CLASSIC;
    end else if (more_s) begin
      cti_s = INC;
    end else begin
      cti_s = EOB;
    end
    return cti_s;
  endfunction

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone B3 classic burst master: turns one command (address, beat count,
// direction) into a single linear incrementing burst. Write data is pulled
// from a valid/ready stream, read data is pushed out on a valid-only stream.
module wb_burst_master
  import wb_common::*;
#(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int lw = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // command
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [lw-1:0] cmd_len_i,
  // write stream
  input  logic [dw-1:0] wdat_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  // read stream
  output logic [dw-1:0] rdat_o,
  output logic          rdat_valid_o,
  // completion
  output logic          done_o,
  output logic          err_o,
  // Wishbone master
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [dw-1:0] wb_dat_i
);

  localparam logic [aw-1:0] ADR_MASK = {{(aw-2){1'b1}}, 2'b00};
  localparam logic [aw-1:0] ADR_STEP = aw'(4);
  localparam logic [lw-1:0] LEN_ONE  = lw'(1);
  localparam logic [lw-1:0] LEN_ZERO = {lw{1'b0}};

  bm_state_e     state_r;
  bm_state_e     next_s;
  logic          we_r;
  logic          single_r;
  logic          err_r;
  logic [aw-1:0] adr_r;
  logic [lw-1:0] rem_r;
  logic [dw-1:0] rdat_r;
  logic          rdat_valid_r;

  logic          in_burst_s;
  logic          stb_s;
  logic          beat_ok_s;
  logic          beat_err_s;
  logic          accept_s;

  // Strobe is held off during writes until the stream has data; an error
  // beat is never also counted as a completed beat.
  assign in_burst_s = (state_r == ST_BURST);
  assign stb_s      = in_burst_s & (~we_r | wdat_valid_i);
  assign beat_err_s = stb_s & wb_err_i;
  assign beat_ok_s  = stb_s & wb_ack_i & ~wb_err_i;
  assign accept_s   = (state_r == ST_IDLE) & cmd_valid_i;

  assign wb_adr_o     = adr_r;
  assign wb_dat_o     = (in_burst_s & we_r) ? wdat_i : {dw{1'b0}};
  assign wb_we_o      = in_burst_s & we_r;
  assign wb_sel_o     = 4'hf;
  assign wb_bte_o     = LINEAR;
  assign rdat_o       = rdat_r;
  assign rdat_valid_o = rdat_valid_r;

  // State register; reset abandons any in-flight burst immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and bus/handshake control decode.
  always_comb begin
    next_s       = state_r;
    cmd_ready_o  = 1'b0;
    wb_cyc_o     = 1'b0;
    wb_stb_o     = 1'b0;
    wb_cti_o     = CLASSIC;
    wdat_ready_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_len_i == LEN_ZERO) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_BURST;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = stb_s;
        wb_cti_o = beat_cti(single_r, rem_r > LEN_ONE);
        if (beat_err_s) begin
          next_s = ST_DONE;
        end else if (beat_ok_s) begin
          wdat_ready_o = we_r;
          if (rem_r == LEN_ONE) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_BURST;
          end
        end else begin
          next_s = ST_BURST;
        end
      end
      ST_DONE: begin
        done_o = 1'b1;
        err_o  = err_r;
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // Command latch plus address and beat counters.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_r     <= 1'b0;
      single_r <= 1'b0;
      err_r    <= 1'b0;
      adr_r    <= {aw{1'b0}};
      rem_r    <= LEN_ZERO;
    end else begin
      if (accept_s) begin
        we_r     <= cmd_we_i;
        single_r <= (cmd_len_i == LEN_ONE);
        err_r    <= 1'b0;
        adr_r    <= cmd_adr_i & ADR_MASK;
        rem_r    <= cmd_len_i;
      end else if (beat_err_s) begin
        err_r <= 1'b1;
      end else if (beat_ok_s) begin
        adr_r <= adr_r + ADR_STEP;
        rem_r <= rem_r - LEN_ONE;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Read stream: registered copy of each acknowledged read beat.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rdat_r       <= {dw{1'b0}};
      rdat_valid_r <= 1'b0;
    end else begin
      rdat_valid_r <= beat_ok_s & ~we_r;
      if (beat_ok_s & ~we_r) begin
        rdat_r <= wb_dat_i;
      end else begin
        rdat_r <= rdat_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: a zero-wait slave model with error
// injection, a write-data source with gap injection, and scoreboards for bus
// beats and read-stream data.
module tb_wb_burst_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic [31:0] wdat_i;
  logic        wdat_valid_i;
  logic        wdat_ready_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // stimulus knobs (main process only)
  int          err_beat   = 0;
  int          gap_beat   = -1;
  int          gap_cycles = 0;
  logic        wr_on      = 1'b0;
  logic [31:0] cmd_tag    = 32'd0;

  // source / slave state (owned by one always block)
  logic [31:0] wr_rel   = 32'd0;
  int          gap_cnt  = 0;
  int          slv_beat = 0;

  // monitor state
  int   cyc_cnt  = 0;
  int   done_cnt = 0;
  int   rv_cnt   = 0;
  logic prev_rd_ack = 1'b0;

  logic err_now;
  logic gap_on;

  wb_burst_master dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_len_i    (cmd_len_i),
    .wdat_i       (wdat_i),
    .wdat_valid_i (wdat_valid_i),
    .wdat_ready_o (wdat_ready_o),
    .rdat_o       (rdat_o),
    .rdat_valid_o (rdat_valid_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_cti_o     (wb_cti_o),
    .wb_bte_o     (wb_bte_o),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .wb_dat_i     (wb_dat_i)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // zero-wait slave with error injection on a chosen (1-based) beat
  assign err_now  = (slv_beat == err_beat - 1);
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ~err_now;
  assign wb_err_i = wb_cyc_o & wb_stb_o & err_now;
  assign wb_dat_i = wb_adr_o ^ 32'h5A5A_0000;

  // write source with a gap before a chosen (0-based) beat
  assign gap_on       = wb_cyc_o & (int'(wr_rel) == gap_beat) & (gap_cnt < gap_cycles);
  assign wdat_valid_i = wr_on & ~gap_on;
  assign wdat_i       = 32'hD000_0000 + (cmd_tag << 4) + wr_rel;

  // source / slave bookkeeping, cleared on command accept
  always @(posedge clk) begin
    if (cmd_valid_i && cmd_ready_o) begin
      wr_rel   <= 32'd0;
      gap_cnt  <= 0;
      slv_beat <= 0;
    end else begin
      if (wdat_valid_i && wdat_ready_o) wr_rel <= wr_rel + 32'd1;
      if (gap_on) gap_cnt <= gap_cnt + 1;
      if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) slv_beat <= slv_beat + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // bus and read-stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_cyc_o) cyc_cnt <= cyc_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
        if (beat_q.size() == 0) begin
          check_val("beat_unexpected", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          check_val("beat_adr", wb_adr_o, e.adr);
          check_val("beat_cti", 32'(wb_cti_o), 32'(e.cti));
          check_val("beat_we", 32'(wb_we_o), 32'(e.we));
          check_val("beat_sel_bte", {26'd0, wb_sel_o, wb_bte_o}, {26'd0, 4'hf, 2'b00});
          check_val("wdat_ready_ack", 32'(wdat_ready_o), 32'(e.we));
          if (e.we) check_val("beat_wdat", wb_dat_o, e.dat);
        end
      end
      if (wb_cyc_o && wb_stb_o && wb_err_i) check_val("wdat_ready_err", 32'(wdat_ready_o), 32'd0);
      if (wb_cyc_o && !wb_stb_o) begin
        if (beat_q.size() == 0) begin
          check_val("wait_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("wait_adr_hold", wb_adr_o, beat_q[0].adr);
          check_val("wait_cti_hold", 32'(wb_cti_o), 32'(beat_q[0].cti));
        end
      end
      if (rdat_valid_o) begin
        rv_cnt <= rv_cnt + 1;
        check_val("rvalid_after_ack", 32'(prev_rd_ack), 32'd1);
        if (rd_q.size() == 0) begin
          check_val("rdat_unexpected", 32'd1, 32'd0);
        end else begin
          logic [31:0] r;
          r = rd_q.pop_front();
          check_val("rdat", rdat_o, r);
        end
      end
      prev_rd_ack <= wb_cyc_o & wb_stb_o & wb_ack_i & ~wb_err_i & ~wb_we_o;
    end
  end

  // push expected beats and read data for one command
  task automatic push_exp(input logic we, input logic [31:0] adr, input int len, input int nacked);
    logic [31:0] base;
    base = adr & 32'hFFFF_FFFC;
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.adr = base + 32'(4 * k);
      b.cti = (len == 1) ? 3'b000 : ((k == len - 1) ? 3'b111 : 3'b010);
      b.we  = we;
      b.dat = we ? (32'hD000_0000 + (cmd_tag << 4) + 32'(k)) : 32'd0;
      beat_q.push_back(b);
      if (!we && k < nacked) rd_q.push_back(b.adr ^ 32'h5A5A_0000);
    end
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] adr, input int len,
                         input int eb, input int gb, input int gc);
    int nacked, lat, n, d0, c0, r0;
    logic got;
    cmd_tag    = cmd_tag + 32'd1;
    err_beat   = eb;
    gap_beat   = gb;
    gap_cycles = gc;
    wr_on      = we;
    nacked     = (eb > 0) ? eb - 1 : len;
    lat        = (len == 0) ? 0 : (((eb > 0) ? eb : len) + gc);
    push_exp(we, adr, len, nacked);
    d0 = done_cnt; c0 = cyc_cnt; r0 = rv_cnt;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = 8'(len);
    cmd_valid_i = 1'b1;
    check_val("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    n = 0; got = 1'b0;
    while (n < 64 && !got) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check_val("done_seen", 32'(got), 32'd1);
    check_val("done_latency", 32'(n), 32'(lat));
    check_val("err_with_done", 32'(err_o), 32'(eb > 0));
    check_val("rvalid_with_done", 32'(rdat_valid_o), 32'(!we && eb == 0 && len > 0));
    check_val("cmd_ready_done", 32'(cmd_ready_o), 32'd0);
    check_val("cyc_in_done", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);
    #1;
    check_val("done_pulses", 32'(done_cnt - d0), 32'd1);
    check_val("cyc_cycles", 32'(cyc_cnt - c0), 32'(lat));
    check_val("rvalid_pulses", 32'(rv_cnt - r0), we ? 32'd0 : 32'(nacked));
    check_val("beats_left", 32'(beat_q.size()), 32'(len - nacked));
    check_val("rdat_left", 32'(rd_q.size()), 32'd0);
    check_val("cmd_ready_back", 32'(cmd_ready_o), 32'd1);
    beat_q.delete();
    rd_q.delete();
    wr_on = 1'b0; err_beat = 0; gap_beat = -1; gap_cycles = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_cyc_stb"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check_val({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    check_val({tag, "_adr"}, wb_adr_o, 32'd0);
    check_val({tag, "_sel_bte_cti"}, {23'd0, wb_sel_o, wb_bte_o, wb_cti_o}, {23'd0, 4'hf, 2'b00, 3'b000});
    check_val({tag, "_flags"}, {27'd0, done_o, err_o, rdat_valid_o, wdat_ready_o, wb_we_o}, 32'd0);
  endtask

  // global time guard
  initial begin
    #400000;
    $display("FAIL global_timeout: got 1, want 0");
    $fatal(1, "time limit");
  end

  initial begin
    int n, d0;
    logic seen;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 32'd0; cmd_len_i = 8'd0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_cmd(1'b0, 32'h0000_0100, 4, 0, -1, 0);   // read burst of 4
    run_cmd(1'b1, 32'h0000_0020, 1, 0, -1, 0);   // single write, classic cti
    run_cmd(1'b1, 32'h0000_0200, 3, 0, 1, 2);    // write with 2-cycle data gap
    run_cmd(1'b0, 32'h0000_0300, 8, 3, -1, 0);   // read, error on beat 3
    run_cmd(1'b0, 32'h0000_0403, 2, 0, -1, 0);   // next command; low bits ignored
    run_cmd(1'b0, 32'h0000_0500, 0, 0, -1, 0);   // zero-length command
    run_cmd(1'b1, 32'h0000_0600, 4, 2, -1, 0);   // write, error on beat 2

    // reset in the middle of a burst
    cmd_tag = cmd_tag + 32'd1;
    push_exp(1'b0, 32'hFFFF_FFF8, 4, 4);
    cmd_we_i = 1'b0; cmd_adr_i = 32'hFFFF_FFF8; cmd_len_i = 8'd4; cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 16 && !seen) begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o && wb_ack_i) seen = 1'b1;
      n++;
    end
    check_val("rst_first_ack", 32'(seen), 32'd1);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    beat_q.delete();
    rd_q.delete();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o || wb_cyc_o) seen = 1'b1;
    end
    check_val("midrst_quiet", 32'(seen), 32'd0);
    check_val("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk);
    #1;

    run_cmd(1'b0, 32'hFFFF_FFF8, 4, 0, -1, 0);   // address wraps past 2^32

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
